// File: rtl/fir_engine.sv
// ---------------------------------------------------------------------------
// fir_engine
// FIR compute engine that sits between the input sample RAM and the output
// RAM. On start it takes over both RAM address muxes, convolves the stored
// samples x[] with the coefficient RAM h[], writes rounded and saturated
// results y[] to the output RAM, pulses done and hands the RAMs back to AXI.
//
//   y[n] = sum_{k=0}^{T(n)-1} h[k] * x[n-k],  T(n) = min(n+1, n_taps)
//
// Ports
//   a_clk, a_rst          clock, synchronous active-high reset
//   start                 one-cycle job request, honoured only in IDLE
//   n_samples, n_taps     job size (0..2^ADDR_WIDTH), latched on start
//   busy, done            job in progress / one-cycle end-of-job pulse
//   sel_mux_wej/wyj       engine owns input / output RAM address (= busy)
//   adr_probki, probka    input RAM read address / data (1-cycle latency)
//   adr_wsp, wsp          coefficient RAM read address / data (1-cycle)
//   adr_wyniku, wynik     output RAM write address / data
//   wyj_wr                output RAM write enable, one pulse per result
// ---------------------------------------------------------------------------
module fir_engine #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int RES_WIDTH  = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int FRAC_BITS  = 15
) (
  input  logic                         a_clk,
  input  logic                         a_rst,
  input  logic                         start,
  input  logic [ADDR_WIDTH:0]          n_samples,
  input  logic [ADDR_WIDTH:0]          n_taps,
  output logic                         busy,
  output logic                         done,
  output logic                         sel_mux_wej,
  output logic                         sel_mux_wyj,
  output logic [ADDR_WIDTH-1:0]        adr_probki,
  input  logic signed [DATA_WIDTH-1:0] probka,
  output logic [ADDR_WIDTH-1:0]        adr_wsp,
  input  logic signed [COEF_WIDTH-1:0] wsp,
  output logic [ADDR_WIDTH-1:0]        adr_wyniku,
  output logic signed [RES_WIDTH-1:0]  wynik,
  output logic                         wyj_wr
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int PW = DATA_WIDTH + COEF_WIDTH;
  localparam logic [CW-1:0]         C_ONE     = CW'(1);
  localparam logic [CW-1:0]         C_TWO     = CW'(2);
  localparam logic [ADDR_WIDTH-1:0] C_ADR_ONE = ADDR_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] C_HALF =
    {{(ACC_WIDTH-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] C_RES_MAX =
    {{(ACC_WIDTH-RES_WIDTH+1){1'b0}}, {(RES_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] C_RES_MIN =
    {{(ACC_WIDTH-RES_WIDTH+1){1'b1}}, {(RES_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_MAC, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t                        r_state;
  logic [CW-1:0]                 r_nSamples;
  logic [CW-1:0]                 r_nTaps;
  logic [CW-1:0]                 r_n;
  logic [CW-1:0]                 r_k;
  logic [CW-1:0]                 r_t;
  logic                          r_vld;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic                          r_busy;
  logic                          r_done;
  logic [ADDR_WIDTH-1:0]         r_adrProbki;
  logic [ADDR_WIDTH-1:0]         r_adrWsp;
  logic [ADDR_WIDTH-1:0]         r_adrWyniku;
  logic signed [RES_WIDTH-1:0]   r_wynik;
  logic                          r_wyjWr;

  logic signed [PW-1:0]          w_prod;
  logic signed [ACC_WIDTH-1:0]   w_prodExt;
  logic signed [ACC_WIDTH-1:0]   w_accNext;
  logic signed [ACC_WIDTH-1:0]   w_rounded;
  logic signed [ACC_WIDTH-1:0]   w_shifted;
  logic signed [RES_WIDTH-1:0]   w_sat;
  logic [CW-1:0]                 w_kInc;
  logic [CW-1:0]                 w_nInc;
  logic [CW-1:0]                 w_nInc2;
  logic [CW-1:0]                 w_tFirst;
  logic [CW-1:0]                 w_tNext;

  // Number of taps that contribute to a sample: the history runs out before
  // the coefficient list does for the first n_taps-1 samples.
  function automatic logic [CW-1:0] tapsFor(input logic [CW-1:0] nPlusOne,
                                            input logic [CW-1:0] nTaps);
    return (nPlusOne < nTaps) ? nPlusOne : nTaps;
  endfunction

  // The RAM data seen this cycle belongs to the address issued last cycle,
  // so the product is only added when the one-deep valid pipe says so.
  assign w_prod    = probka * wsp;
  assign w_prodExt = {{(ACC_WIDTH-PW){w_prod[PW-1]}}, w_prod};
  assign w_accNext = r_acc + (r_vld ? w_prodExt : '0);
  assign w_rounded = w_accNext + C_HALF;
  assign w_shifted = w_rounded >>> FRAC_BITS;

  assign w_kInc   = r_k + C_ONE;
  assign w_nInc   = r_n + C_ONE;
  assign w_nInc2  = r_n + C_TWO;
  assign w_tFirst = tapsFor(C_ONE, r_nTaps);
  assign w_tNext  = tapsFor(w_nInc2, r_nTaps);

  // Clamp the rounded accumulator into the signed result range.
  always_comb begin
    w_sat = w_shifted[RES_WIDTH-1:0];
    if (w_shifted > C_RES_MAX) begin
      w_sat = C_RES_MAX[RES_WIDTH-1:0];
    end else if (w_shifted < C_RES_MIN) begin
      w_sat = C_RES_MIN[RES_WIDTH-1:0];
    end
  end

  // Main control FSM. All outputs are registered and set on the edge that
  // enters the state they belong to, so RAM addresses for MAC step k are
  // already stable during that step. A sample with no taps skips MAC and
  // goes straight to DRAIN with a cleared accumulator.
  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      r_state     <= S_IDLE;
      r_nSamples  <= '0;
      r_nTaps     <= '0;
      r_n         <= '0;
      r_k         <= '0;
      r_t         <= '0;
      r_vld       <= 1'b0;
      r_acc       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_adrProbki <= '0;
      r_adrWsp    <= '0;
      r_adrWyniku <= '0;
      r_wynik     <= '0;
      r_wyjWr     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_nSamples <= n_samples;
            r_nTaps    <= n_taps;
            r_busy     <= 1'b1;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_n   <= '0;
          r_acc <= '0;
          r_vld <= 1'b0;
          if (r_nSamples == '0) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_t         <= w_tFirst;
            r_k         <= '0;
            r_adrProbki <= '0;
            r_adrWsp    <= '0;
            r_state     <= (w_tFirst == '0) ? S_DRAIN : S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_accNext;
          r_vld <= 1'b1;
          if (w_kInc == r_t) begin
            r_state <= S_DRAIN;
          end else begin
            r_k         <= w_kInc;
            r_adrProbki <= r_adrProbki - C_ADR_ONE;
            r_adrWsp    <= r_adrWsp + C_ADR_ONE;
          end
        end
        S_DRAIN: begin
          r_acc       <= w_accNext;
          r_vld       <= 1'b0;
          r_wynik     <= w_sat;
          r_wyjWr     <= 1'b1;
          r_adrWyniku <= r_n[ADDR_WIDTH-1:0];
          r_state     <= S_WRITE;
        end
        S_WRITE: begin
          r_wyjWr <= 1'b0;
          r_acc   <= '0;
          r_n     <= w_nInc;
          if (w_nInc < r_nSamples) begin
            r_t         <= w_tNext;
            r_k         <= '0;
            r_adrProbki <= w_nInc[ADDR_WIDTH-1:0];
            r_adrWsp    <= '0;
            r_state     <= (w_tNext == '0) ? S_DRAIN : S_MAC;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign sel_mux_wej = r_busy;
  assign sel_mux_wyj = r_busy;
  assign adr_probki  = r_adrProbki;
  assign adr_wsp     = r_adrWsp;
  assign adr_wyniku  = r_adrWyniku;
  assign wynik       = r_wynik;
  assign wyj_wr      = r_wyjWr;

endmodule

// File: tb/tb_fir_engine.sv
// ---------------------------------------------------------------------------
// tb_fir_engine
// Testbench for fir_engine. Models the input and coefficient RAMs with a
// one-cycle read latency, queues the expected output RAM writes when a job
// is set up, and a separate monitor pops and compares on every write.
// ---------------------------------------------------------------------------
module tb_fir_engine;

  localparam int AW = 13;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } exp_t;

  logic               a_clk = 1'b0;
  logic               a_rst = 1'b1;
  logic               start = 1'b0;
  logic [AW:0]        n_samples = '0;
  logic [AW:0]        n_taps = '0;
  logic               busy;
  logic               done;
  logic               sel_mux_wej;
  logic               sel_mux_wyj;
  logic [AW-1:0]      adr_probki;
  logic signed [15:0] probka = '0;
  logic [AW-1:0]      adr_wsp;
  logic signed [15:0] wsp = '0;
  logic [AW-1:0]      adr_wyniku;
  logic signed [15:0] wynik;
  logic               wyj_wr;

  logic signed [15:0] xMem [0:8191];
  logic signed [15:0] hMem [0:8191];

  exp_t expQ[$];
  exp_t monE;
  int   checks = 0;
  int   errors = 0;
  int   writeCount = 0;
  int   lastWrAddr = -1;

  fir_engine dut (
    .a_clk       (a_clk),
    .a_rst       (a_rst),
    .start       (start),
    .n_samples   (n_samples),
    .n_taps      (n_taps),
    .busy        (busy),
    .done        (done),
    .sel_mux_wej (sel_mux_wej),
    .sel_mux_wyj (sel_mux_wyj),
    .adr_probki  (adr_probki),
    .probka      (probka),
    .adr_wsp     (adr_wsp),
    .wsp         (wsp),
    .adr_wyniku  (adr_wyniku),
    .wynik       (wynik),
    .wyj_wr      (wyj_wr)
  );

  // 100 MHz clock shared by the engine and the RAM models.
  always #5 a_clk = ~a_clk;

  // Synchronous-read RAM models: data for an address appears one cycle later.
  always @(posedge a_clk) begin
    probka <= xMem[adr_probki];
    wsp    <= hMem[adr_wsp];
  end

  // Output RAM monitor: every write strobe must match the oldest expectation.
  always @(negedge a_clk) begin
    if (wyj_wr === 1'b1) begin
      writeCount++;
      lastWrAddr = int'(adr_wyniku);
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write addr=%0h data=%0h required=no write",
                 adr_wyniku, wynik);
      end else begin
        monE = expQ.pop_front();
        if (adr_wyniku !== monE.addr || wynik !== monE.data) begin
          errors++;
          $display("[TB] FAIL write addr=%0h data=%0h required addr=%0h data=%0h",
                   adr_wyniku, wynik, monE.addr, monE.data);
        end
      end
    end
  end

  // Reference arithmetic for one accumulator value: round half up, then clamp.
  function automatic logic [15:0] roundSat(input longint acc);
    longint r;
    r = (acc + 64'sd16384) >>> 15;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  task automatic checkOutput(input string name, input longint actual,
                             input longint required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic pushExp(input int addr, input logic [15:0] data);
    exp_t e;
    e.addr = AW'(addr);
    e.data = data;
    expQ.push_back(e);
  endtask

  task automatic pulseStart(input int nS, input int nT);
    @(negedge a_clk);
    n_samples = (AW+1)'(nS);
    n_taps    = (AW+1)'(nT);
    start     = 1'b1;
    @(negedge a_clk);
    start     = 1'b0;
  endtask

  // Launch a job and count cycles until done; cycle 1 is the one right after
  // the start edge. An optional extra start pulse is driven mid-job.
  task automatic applyStimulus(input int nS, input int nT, input int restartAt,
                               input int budget, output int latency,
                               output int busyCnt);
    int cnt;
    int selErr;
    cnt = 1;
    selErr = 0;
    latency = -1;
    busyCnt = 0;
    pulseStart(nS, nT);
    forever begin
      if (sel_mux_wej !== busy || sel_mux_wyj !== busy) selErr++;
      if (busy === 1'b1) busyCnt++;
      if (done === 1'b1) begin
        latency = cnt;
        break;
      end
      if (cnt >= budget) break;
      start = (cnt == restartAt);
      @(negedge a_clk);
      cnt++;
    end
    start = 1'b0;
    checkOutput("sel_tracks_busy", selErr, 0);
  endtask

  // Common end-of-job checks, including the return to IDLE one cycle later.
  task automatic finishJob(input string name, input int lat, input int expLat,
                           input int w0, input int expWrites);
    checkOutput({name, "_latency"}, lat, expLat);
    checkOutput({name, "_writes"}, writeCount - w0, expWrites);
    checkOutput({name, "_queue_left"}, expQ.size(), 0);
    @(negedge a_clk);
    checkOutput({name, "_idle_busy_done"}, {busy, done}, 0);
  endtask

  initial begin
    int lat;
    int bc;
    int w0;
    int found;

    for (int i = 0; i < 8192; i++) begin
      xMem[i] = '0;
      hMem[i] = '0;
    end

    $display("[TB] reset state");
    a_rst = 1'b1;
    repeat (3) @(negedge a_clk);
    checkOutput("rst_busy_done", {busy, done}, 0);
    checkOutput("rst_sel", {sel_mux_wej, sel_mux_wyj}, 0);
    checkOutput("rst_wyj_wr", wyj_wr, 0);
    checkOutput("rst_addrs", {adr_probki, adr_wsp, adr_wyniku}, 0);
    checkOutput("rst_wynik", wynik, 0);
    a_rst = 1'b0;

    $display("[TB] T1 impulse");
    xMem[0] = 16'sh7FFF; xMem[1] = 0; xMem[2] = 0; xMem[3] = 0;
    hMem[0] = 16'sh4000; hMem[1] = 16'sh2000;
    pushExp(0, 16'h4000); pushExp(1, 16'h2000);
    pushExp(2, 16'h0000); pushExp(3, 16'h0000);
    w0 = writeCount;
    applyStimulus(4, 2, 0, 100, lat, bc);
    finishJob("t1", lat, 17, w0, 4);

    $display("[TB] T2 positive saturation");
    hMem[0] = 16'sh7FFF; hMem[1] = 16'sh7FFF;
    xMem[0] = 16'sh7FFF; xMem[1] = 16'sh7FFF;
    pushExp(0, 16'h7FFE); pushExp(1, 16'h7FFF);
    w0 = writeCount;
    applyStimulus(2, 2, 0, 100, lat, bc);
    finishJob("t2p", lat, 9, w0, 2);

    $display("[TB] T2 negative saturation");
    xMem[0] = -16'sh8000; xMem[1] = -16'sh8000;
    pushExp(0, 16'h8001); pushExp(1, 16'h8000);
    w0 = writeCount;
    applyStimulus(2, 2, 0, 100, lat, bc);
    finishJob("t2n", lat, 9, w0, 2);

    $display("[TB] T3 empty job");
    w0 = writeCount;
    applyStimulus(0, 2, 0, 100, lat, bc);
    checkOutput("t3_busy_cycles", bc, 2);
    finishJob("t3e", lat, 2, w0, 0);

    $display("[TB] T3 zero taps");
    pushExp(0, 16'h0000); pushExp(1, 16'h0000); pushExp(2, 16'h0000);
    w0 = writeCount;
    applyStimulus(3, 0, 0, 100, lat, bc);
    finishJob("t3z", lat, 8, w0, 3);

    $display("[TB] rounding half up");
    hMem[0] = 16'sh0001;
    xMem[0] = 16'sh4000; xMem[1] = -16'sh4000; xMem[2] = -16'sh4001;
    pushExp(0, 16'h0001); pushExp(1, 16'h0000); pushExp(2, 16'hFFFF);
    w0 = writeCount;
    applyStimulus(3, 1, 0, 100, lat, bc);
    finishJob("round", lat, 11, w0, 3);

    $display("[TB] T4 timing with ignored restart");
    hMem[0] = 16'sh4000; hMem[1] = 16'sh2000; hMem[2] = 16'sh1000; hMem[3] = 16'sh0800;
    xMem[0] = 16'sh0100; xMem[1] = 16'sh0200; xMem[2] = 16'sh0300;
    pushExp(0, 16'h0080); pushExp(1, 16'h0140); pushExp(2, 16'h0220);
    w0 = writeCount;
    applyStimulus(3, 4, 5, 100, lat, bc);
    finishJob("t4", lat, 14, w0, 3);

    $display("[TB] T5 reset mid-job");
    hMem[0] = 16'sh4000; hMem[1] = 16'sh0000;
    xMem[0] = 16'sh2000;
    pushExp(0, 16'h1000);
    w0 = writeCount;
    pulseStart(16, 2);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (wyj_wr === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge a_clk);
    end
    checkOutput("t5_first_write_seen", found, 1);
    @(negedge a_clk);
    a_rst = 1'b1;
    @(negedge a_clk);
    checkOutput("t5_rst_busy_done", {busy, done}, 0);
    checkOutput("t5_rst_sel", {sel_mux_wej, sel_mux_wyj}, 0);
    checkOutput("t5_rst_addrs", {adr_probki, adr_wsp, adr_wyniku}, 0);
    a_rst = 1'b0;
    repeat (40) @(negedge a_clk);
    checkOutput("t5_writes", writeCount - w0, 1);
    checkOutput("t5_queue_left", expQ.size(), 0);
    checkOutput("t5_stays_idle", busy, 0);

    $display("[TB] T5 job after reset");
    xMem[0] = 16'sh7FFF; xMem[1] = 0; xMem[2] = 0; xMem[3] = 0;
    hMem[0] = 16'sh4000; hMem[1] = 16'sh2000;
    pushExp(0, 16'h4000); pushExp(1, 16'h2000);
    pushExp(2, 16'h0000); pushExp(3, 16'h0000);
    w0 = writeCount;
    applyStimulus(4, 2, 0, 100, lat, bc);
    finishJob("t5r", lat, 17, w0, 4);

    $display("[TB] T6 full size");
    hMem[0] = 16'sh7FFF;
    for (int i = 0; i < 8192; i++) begin
      xMem[i] = 16'(i * 4);
      pushExp(i, roundSat(longint'(xMem[i]) * 64'sd32767));
    end
    w0 = writeCount;
    applyStimulus(8192, 1, 0, 30000, lat, bc);
    checkOutput("t6_last_addr", lastWrAddr, 8191);
    finishJob("t6", lat, 24578, w0, 8192);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
